// File: rtl/bip_pkg.sv
// bip_pkg: definitions shared by the BIP program loader, program memory and
// control unit.
//   - BIP_NB_DATA / BIP_NB_BYTE / BIP_N_ADDR / BIP_LOG2_N_INSMEM_ADDR : defaults
//   - BIP_HALT_WORD : end-of-program instruction
//   - state_t       : loader FSM states
// Optional feature macro: BIP_LOADER_CHECKSUM_EN (adds the ST_CHECK state).
package bip_pkg;

    localparam int unsigned BIP_NB_DATA            = 16;
    localparam int unsigned BIP_NB_BYTE            = 8;
    localparam int unsigned BIP_N_ADDR             = 2048;
    localparam int unsigned BIP_LOG2_N_INSMEM_ADDR = 11;
    localparam logic [BIP_NB_DATA-1:0] BIP_HALT_WORD = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_LO = 3'd1,
        ST_LOAD_HI = 3'd2,
        ST_WRITE   = 3'd3,
`ifdef BIP_LOADER_CHECKSUM_EN
        ST_CHECK   = 3'd4,
`endif
        ST_DONE    = 3'd5,
        ST_RUN     = 3'd6
    } state_t;

endpackage

// File: rtl/bip_byte_assembler.sv
// bip_byte_assembler: packs two consecutive bytes (low first) into one word.
// Ports:
//   i_clock, i_reset  : clock, synchronous active-high reset
//   valid_i           : byte strobe (already qualified by the caller)
//   hi_i              : 1 = the strobed byte is the high byte
//   byte_i            : received byte
//   word_o            : {byte_i, latched low byte}, meaningful with word_valid_o
//   word_valid_o      : high in the cycle the high byte is strobed
module bip_byte_assembler #(
    parameter int unsigned NB_BYTE = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   valid_i,
    input  logic                   hi_i,
    input  logic [NB_BYTE-1:0]     byte_i,
    output logic [2*NB_BYTE-1:0]   word_o,
    output logic                   word_valid_o
);

    logic [NB_BYTE-1:0] lo_q, lo_d;

    always_comb begin
        lo_d = lo_q;
        if (valid_i && !hi_i) begin
            lo_d = byte_i;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            lo_q <= '0;
        end else begin
            lo_q <= lo_d;
        end
    end

    // The high byte is used straight from the input so the word is ready
    // in the same cycle it completes.
    assign word_o       = {byte_i, lo_q};
    assign word_valid_o = valid_i & hi_i;

endmodule

// File: rtl/bip_program_loader.sv
// bip_program_loader: loads the BIP program memory from a UART byte stream and
// hands the memory port to the CPU fetch path once loading completes.
// Ports:
//   i_clock, i_reset         : clock, synchronous active-high reset
//   i_start_load             : pulse, start a new load (IDLE or RUN only)
//   i_rx_data, i_rx_valid    : received byte and its one-cycle strobe
//   i_cpu_addr, i_cpu_enable : CPU fetch address / request (used in RUN)
//   o_mem_addr               : program memory address (registered, CPU mux in RUN)
//   o_mem_wr_data, o_mem_wr_en : registered write data / strobe
//   o_mem_rd_en              : program memory read enable (RUN only)
//   o_cpu_stall              : high in every state except RUN
//   o_load_done              : one-cycle pulse when the load completes
//   o_load_count             : words written by the last load
//   o_error                  : sticky overflow (or checksum) error
// Optional feature macro: BIP_LOADER_CHECKSUM_EN -- after the HALT word, one
// more byte is compared against the XOR of all program bytes.
module bip_program_loader
    import bip_pkg::*;
#(
    parameter int unsigned NB_DATA            = BIP_NB_DATA,
    parameter int unsigned NB_BYTE            = BIP_NB_BYTE,
    parameter int unsigned N_ADDR             = BIP_N_ADDR,
    parameter int unsigned LOG2_N_INSMEM_ADDR = BIP_LOG2_N_INSMEM_ADDR,
    parameter logic [NB_DATA-1:0] HALT_WORD   = BIP_HALT_WORD
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start_load,
    input  logic [NB_BYTE-1:0]            i_rx_data,
    input  logic                          i_rx_valid,
    input  logic [LOG2_N_INSMEM_ADDR-1:0] i_cpu_addr,
    input  logic                          i_cpu_enable,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_mem_addr,
    output logic [NB_DATA-1:0]            o_mem_wr_data,
    output logic                          o_mem_wr_en,
    output logic                          o_mem_rd_en,
    output logic                          o_cpu_stall,
    output logic                          o_load_done,
    output logic [LOG2_N_INSMEM_ADDR:0]   o_load_count,
    output logic                          o_error
);

    localparam int unsigned AW = LOG2_N_INSMEM_ADDR;
    localparam int unsigned CW = LOG2_N_INSMEM_ADDR + 1;

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [NB_DATA-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              error_q, error_d;
`ifdef BIP_LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] xor_q, xor_d;
`endif

    logic               rx_take;
    logic [NB_DATA-1:0] asm_word;
    logic               asm_word_valid;

    // Bytes are only consumed while waiting for one; anything arriving in
    // other states (including alongside a start pulse) is dropped.
    assign rx_take = i_rx_valid && ((state_q == ST_LOAD_LO) || (state_q == ST_LOAD_HI));

    bip_byte_assembler #(
        .NB_BYTE (NB_BYTE)
    ) u_byte_assembler (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .valid_i      (rx_take),
        .hi_i         (state_q == ST_LOAD_HI),
        .byte_i       (i_rx_data),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        error_d   = error_q;
`ifdef BIP_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
        if (rx_take) begin
            xor_d = xor_q ^ i_rx_data;
        end
`endif
        case (state_q)
            ST_IDLE, ST_RUN: begin
                // A new load also clears the sticky error of the previous one.
                if (i_start_load) begin
                    state_d = ST_LOAD_LO;
                    ptr_d   = '0;
                    count_d = '0;
                    error_d = 1'b0;
`ifdef BIP_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            ST_LOAD_LO: begin
                if (rx_take) begin
                    state_d = ST_LOAD_HI;
                end
            end
            ST_LOAD_HI: begin
                // Write outputs are loaded on entry so the strobe is live
                // for exactly the WRITE cycle.
                if (asm_word_valid) begin
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    addr_d    = ptr_q;
                    wr_data_d = asm_word;
                end
            end
            ST_WRITE: begin
                ptr_d   = ptr_q + AW'(1);
                count_d = count_q + CW'(1);
                if (wr_data_q == HALT_WORD) begin
`ifdef BIP_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else if (count_q == CW'(N_ADDR - 1)) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD_LO;
                end
            end
`ifdef BIP_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_rx_valid) begin
                    if (i_rx_data != xor_q) begin
                        error_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            error_q   <= 1'b0;
`ifdef BIP_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            error_q   <= error_d;
`ifdef BIP_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    // In RUN the CPU address bypasses the register so fetch latency is just
    // the memory's own read latency.
    assign o_mem_addr    = (state_q == ST_RUN) ? i_cpu_addr : addr_q;
    assign o_mem_wr_data = wr_data_q;
    assign o_mem_wr_en   = wr_en_q;
    assign o_mem_rd_en   = (state_q == ST_RUN) && i_cpu_enable;
    assign o_cpu_stall   = (state_q != ST_RUN);
    assign o_load_done   = (state_q == ST_DONE);
    assign o_load_count  = count_q;
    assign o_error       = error_q;

endmodule

// File: doc/bip_program_loader.md
Name: bip_program_loader

Overview:
- Sequences the BIP program memory during bring-up: assembles 16-bit instructions from a byte stream (UART RX) and writes them to consecutive program-memory addresses starting at 0.
- Arbitrates the single memory address port between the loader (write) and the CPU fetch path (read).
- While loading, the CPU is held in stall. After load completes, memory ownership passes to the CPU fetch path until the next load request.

Parameters:
- NB_DATA, 16, instruction width (must be 2*NB_BYTE)
- NB_BYTE, 8, RX byte width
- N_ADDR, 2048, program memory depth
- LOG2_N_INSMEM_ADDR, 11, address width
- HALT_WORD, 16'h0000, end-of-program instruction

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous reset, active-high
- i_start_load  in  1  pulse: begin a new program load
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_cpu_addr  in  LOG2_N_INSMEM_ADDR  fetch address from CPU control unit
- i_cpu_enable  in  1  CPU fetch request
- o_mem_addr  out  LOG2_N_INSMEM_ADDR  address to program memory
- o_mem_wr_data  out  NB_DATA  write data to program memory
- o_mem_wr_en  out  1  write strobe
- o_mem_rd_en  out  1  read enable (program memory i_enable)
- o_cpu_stall  out  1  CPU must hold its PC
- o_load_done  out  1  one-cycle pulse at load completion
- o_load_count  out  LOG2_N_INSMEM_ADDR+1  instructions written in last load
- o_error  out  1  sticky: overflow (or checksum fail)

Behaviour:
- Reset values:
  - o_mem_addr=0, o_mem_wr_data=0, o_mem_wr_en=0, o_mem_rd_en=0.
  - o_cpu_stall=1, o_load_done=0, o_load_count=0, o_error=0.
  - State IDLE, write pointer 0.
- FSM states:
  - IDLE: stall=1, no memory access. i_start_load -> LOAD_LO; clear pointer, count, o_error.
  - LOAD_LO: on i_rx_valid, latch low byte -> LOAD_HI.
  - LOAD_HI: on i_rx_valid, latch high byte -> WRITE.
  - WRITE: exactly one cycle.
    - o_mem_wr_en=1, o_mem_addr=pointer, o_mem_wr_data={hi,lo}.
    - Pointer and count increment.
    - Word==HALT_WORD -> DONE.
    - Else pointer reaches N_ADDR (count==N_ADDR after increment) -> set o_error, go to DONE.
    - Else -> LOAD_LO.
  - DONE: one cycle, o_load_done=1 -> RUN.
  - RUN:
    - stall=0; o_mem_addr=i_cpu_addr (combinational mux); o_mem_rd_en=i_cpu_enable; wr_en=0.
    - i_start_load -> LOAD_LO with pointer/count cleared.
- Registered outputs: o_mem_wr_en/addr/data are registered so the write is visible on the memory clock edge following entry to WRITE. In RUN, read latency is that of the memory (1 cycle).
- Timing: the byte accepted in LOAD_HI produces the write 1 cycle later. A byte arriving while in WRITE or DONE is dropped; the upstream UART rate guarantees at least 2 idle cycles between strobes.
- Stall: o_cpu_stall=1 in every state except RUN. o_mem_rd_en=0 outside RUN.
- Simultaneous events:
  - i_start_load during LOAD_* or WRITE: ignored.
  - i_start_load and i_rx_valid in same cycle in RUN/IDLE: start wins, byte dropped.
- Reset mid-load returns to IDLE immediately. Partially written memory contents are left as-is.
- o_load_count holds its value after DONE until the next start.

Optional Feature:
- Macro: BIP_LOADER_CHECKSUM_EN.
- With the macro defined:
  - Adds state CHECK between WRITE(HALT) and DONE.
  - A running XOR of every received byte is kept.
  - The next byte received in CHECK is compared to the running XOR.
  - Mismatch sets o_error. DONE still follows.
  - The overflow path skips CHECK.
- Without the macro: no CHECK state, no XOR register, HALT goes directly to DONE.

Decomposition:
- Shared package bip_pkg:
  - state encoding localparams (IDLE, LOAD_LO, LOAD_HI, WRITE, CHECK, DONE, RUN)
  - HALT opcode constant
  - NB_DATA and LOG2_N_INSMEM_ADDR defaults, shared with program memory and control unit
- One sub-module is natural: bip_byte_assembler (two-byte-to-word packer with valid-out). The FSM and address mux stay in the top.

Test Plan:
- Reset, then load bytes 34,12,78,56,00,00 -> writes 0x1234@0, 0x5678@1, 0x0000@2; o_load_done pulses; o_load_count=3; stall drops in RUN.
- RUN with i_cpu_enable=1, i_cpu_addr=1 -> o_mem_addr=1, o_mem_rd_en=1, wr_en=0; the memory returns 0x5678 one cycle later.
- Stream 2048 non-HALT words -> last write @2047, o_error=1, o_load_count=2048, enters RUN.
- Assert i_reset after 3 bytes -> IDLE next cycle, stall=1, no further writes; a new start reloads from address 0.
- i_start_load with i_rx_valid in same RUN cycle -> byte dropped; the next two bytes form the word written @0.
- With BIP_LOADER_CHECKSUM_EN: bytes 34,12,00,00 then 0x26 -> o_error=0. Same load with checksum byte 0x27 -> o_error=1, o_load_done still pulses.
